// File: rtl/renode_axi_pkg.sv
// Shared AXI definitions for the Renode bridge family.
// Contents: burst/response encodings, beat size/length types, the error
// counter width and a helper that maps a data width to AXI AxSIZE.
package renode_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_type_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } response_e;

    typedef logic [2:0] burst_size_t;
    typedef logic [7:0] burst_length_t;

    localparam int ErrCountWidth = 16;

    // AxSIZE = log2(bytes per beat); widths that are not 8*2^n map to 0.
    function automatic burst_size_t data_width_to_size(input int data_width);
        burst_size_t size;
        size = '0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == data_width) size = burst_size_t'(i);
        end
        return size;
    endfunction

endpackage

// File: rtl/renode_tcdm_axi_manager_if.sv
// AXI4 bus bundle between the TCDM bridge (manager) and a Renode subordinate.
// Modports: master drives AW/W/AR payloads plus B/R ready; slave the reverse.
interface renode_tcdm_axi_manager_if #(
    parameter int AddressWidth       = 32,
    parameter int DataWidth          = 32,
    parameter int TransactionIdWidth = 8
) ();
    import renode_axi_pkg::*;

    localparam int StrobeWidth = DataWidth / 8;

    // write address
    logic                          awvalid;
    logic                          awready;
    logic [TransactionIdWidth-1:0] awid;
    logic [AddressWidth-1:0]       awaddr;
    burst_length_t                 awlen;
    burst_size_t                   awsize;
    burst_type_e                   awburst;
    // write data
    logic                          wvalid;
    logic                          wready;
    logic [DataWidth-1:0]          wdata;
    logic [StrobeWidth-1:0]        wstrb;
    logic                          wlast;
    // write response
    logic                          bvalid;
    logic                          bready;
    logic [TransactionIdWidth-1:0] bid;
    response_e                     bresp;
    // read address
    logic                          arvalid;
    logic                          arready;
    logic [TransactionIdWidth-1:0] arid;
    logic [AddressWidth-1:0]       araddr;
    burst_length_t                 arlen;
    burst_size_t                   arsize;
    burst_type_e                   arburst;
    // read data
    logic                          rvalid;
    logic                          rready;
    logic [TransactionIdWidth-1:0] rid;
    logic [DataWidth-1:0]          rdata;
    response_e                     rresp;
    logic                          rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

endinterface

// File: rtl/renode_err_counter.sv
// Sticky error flag plus saturating error counter, shared by Renode bridges.
// Ports: clk/rst_n (async active-low), i_err (one event per cycle),
//        o_sticky (set on first event, cleared by reset), o_count (saturating).
module renode_err_counter #(
    parameter int Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_err,
    output logic             o_sticky,
    output logic [Width-1:0] o_count
);
    logic             r_sticky;
    logic [Width-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (i_err) begin
            r_sticky <= 1'b1;
            if (r_count != {Width{1'b1}}) r_count <= r_count + 1'b1;
        end
    end

    assign o_sticky = r_sticky;
    assign o_count  = r_count;

endmodule

// File: rtl/renode_tcdm_axi_manager.sv
// TCDM-to-AXI4 manager bridge. Each granted TCDM request becomes one
// single-beat AXI transaction; only one is in flight at a time.
// Ports: aclk/areset_n (async active-low); i_tcdm_* request side with
//        o_tcdm_gnt (combinational), o_tcdm_r_data/o_tcdm_r_valid completion;
//        axi (master modport); o_err_sticky/o_err_count response error status.
module renode_tcdm_axi_manager
    import renode_axi_pkg::*;
#(
    parameter int                            AddressWidth       = 32,
    parameter int                            DataWidth          = 32,
    parameter int                            TransactionIdWidth = 8,
    parameter logic [TransactionIdWidth-1:0] TransactionId      = '0
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic                       i_tcdm_req,
    output logic                       o_tcdm_gnt,
    input  logic [AddressWidth-1:0]    i_tcdm_add,
    input  logic                       i_tcdm_wen,
    input  logic [DataWidth/8-1:0]     i_tcdm_be,
    input  logic [DataWidth-1:0]       i_tcdm_data,
    output logic [DataWidth-1:0]       o_tcdm_r_data,
    output logic                       o_tcdm_r_valid,
    renode_tcdm_axi_manager_if.master  axi,
    output logic                       o_err_sticky,
    output logic [ErrCountWidth-1:0]   o_err_count
);
    localparam int                      StrobeWidth = DataWidth / 8;
    localparam logic [AddressWidth-1:0] AlignMask   = ~AddressWidth'(StrobeWidth - 1);
    localparam burst_size_t             BeatSize    = data_width_to_size(DataWidth);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD,
        ST_RD_DATA
    } state_e;

    state_e                  r_state;
    logic [AddressWidth-1:0] r_addr;
    logic [DataWidth-1:0]    r_wdata;
    logic [StrobeWidth-1:0]  r_wstrb;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_arvalid;
    logic                    r_bready;
    logic                    r_rready;
    logic [DataWidth-1:0]    r_rdata;
    logic                    r_rvalid;

    logic w_aw_done;
    logic w_w_done;
    logic w_b_err;
    logic w_r_err;

    assign o_tcdm_gnt = i_tcdm_req && (r_state == ST_IDLE);

    // A channel counts as done if it already handshook or handshakes now;
    // AW and W are tracked separately so neither waits on the other's ready.
    assign w_aw_done = !r_awvalid || axi.awready;
    assign w_w_done  = !r_wvalid  || axi.wready;

    assign w_b_err = (r_state == ST_WR_RESP) && axi.bvalid &&
                     ((axi.bresp != RESP_OKAY) || (axi.bid != TransactionId));
    assign w_r_err = (r_state == ST_RD_DATA) && axi.rvalid &&
                     ((axi.rresp != RESP_OKAY) || (axi.rid != TransactionId) || !axi.rlast);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_rready  <= 1'b0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (o_tcdm_gnt) begin
                        // payload frozen here so it stays stable while valid
                        r_addr  <= i_tcdm_add & AlignMask;
                        r_wdata <= i_tcdm_data;
                        r_wstrb <= i_tcdm_be;
                        if (i_tcdm_wen) begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (r_awvalid && axi.awready) r_awvalid <= 1'b0;
                    if (r_wvalid && axi.wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (axi.bvalid) begin
                        r_bready <= 1'b0;
                        r_rvalid <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (axi.rvalid) begin
                        r_rready <= 1'b0;
                        r_rdata  <= axi.rdata;
                        r_rvalid <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign axi.awvalid = r_awvalid;
    assign axi.awid    = TransactionId;
    assign axi.awaddr  = r_addr;
    assign axi.awlen   = '0;
    assign axi.awsize  = BeatSize;
    assign axi.awburst = BURST_INCR;

    assign axi.wvalid  = r_wvalid;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wlast   = 1'b1;

    assign axi.bready  = r_bready;

    assign axi.arvalid = r_arvalid;
    assign axi.arid    = TransactionId;
    assign axi.araddr  = r_addr;
    assign axi.arlen   = '0;
    assign axi.arsize  = BeatSize;
    assign axi.arburst = BURST_INCR;

    assign axi.rready  = r_rready;

    assign o_tcdm_r_data  = r_rdata;
    assign o_tcdm_r_valid = r_rvalid;

    // b and r errors are in mutually exclusive states, so at most one per cycle
    renode_err_counter #(
        .Width (ErrCountWidth)
    ) u_err_counter (
        .clk      (aclk),
        .rst_n    (areset_n),
        .i_err    (w_b_err || w_r_err),
        .o_sticky (o_err_sticky),
        .o_count  (o_err_count)
    );

endmodule

// File: tb/tb_renode_tcdm_axi_manager.sv
module tb_renode_tcdm_axi_manager;
    import renode_axi_pkg::*;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic        tcdm_req = 1'b0;
    logic        tcdm_gnt;
    logic [31:0] tcdm_add = '0;
    logic        tcdm_wen = 1'b0;
    logic [3:0]  tcdm_be = '0;
    logic [31:0] tcdm_data = '0;
    logic [31:0] tcdm_r_data;
    logic        tcdm_r_valid;
    logic        err_sticky;
    logic [15:0] err_count;

    always #5 aclk = ~aclk;

    renode_tcdm_axi_manager_if #(.AddressWidth(32), .DataWidth(32), .TransactionIdWidth(8)) axi_if ();

    renode_tcdm_axi_manager #(
        .AddressWidth(32), .DataWidth(32), .TransactionIdWidth(8), .TransactionId(8'h00)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .i_tcdm_req(tcdm_req), .o_tcdm_gnt(tcdm_gnt), .i_tcdm_add(tcdm_add),
        .i_tcdm_wen(tcdm_wen), .i_tcdm_be(tcdm_be), .i_tcdm_data(tcdm_data),
        .o_tcdm_r_data(tcdm_r_data), .o_tcdm_r_valid(tcdm_r_valid),
        .axi(axi_if),
        .o_err_sticky(err_sticky), .o_err_count(err_count)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: handshake seen with no expectation queued", nm);
    endtask

    // ---------------- subordinate model ----------------
    int        aw_delay = 0;
    response_e rd_resp = RESP_OKAY;
    logic [7:0] next_bid = 8'h00;
    bit        r_hold = 1'b0;

    logic [31:0] mem [0:255];
    int          aw_cnt;
    bit          aw_got, w_got, ar_got;
    logic [31:0] aw_q, ar_q, wd_q;
    logic [3:0]  ws_q;

    always @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            axi_if.awready <= 1'b0; axi_if.wready <= 1'b0; axi_if.bvalid <= 1'b0;
            axi_if.arready <= 1'b0; axi_if.rvalid <= 1'b0;
            axi_if.bid <= '0; axi_if.bresp <= RESP_OKAY;
            axi_if.rid <= '0; axi_if.rresp <= RESP_OKAY; axi_if.rdata <= '0; axi_if.rlast <= 1'b1;
            aw_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_q <= '0; ar_q <= '0; wd_q <= '0; ws_q <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (axi_if.awvalid && !aw_got) begin
                if (axi_if.awready) begin
                    aw_got <= 1'b1; axi_if.awready <= 1'b0; aw_q <= axi_if.awaddr;
                end else if (aw_cnt >= aw_delay) axi_if.awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            // W is only accepted after AW has completed
            if (axi_if.wvalid && aw_got && !w_got) begin
                if (axi_if.wready) begin
                    w_got <= 1'b1; axi_if.wready <= 1'b0; wd_q <= axi_if.wdata; ws_q <= axi_if.wstrb;
                end else axi_if.wready <= 1'b1;
            end
            if (aw_got && w_got && !axi_if.bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (ws_q[b]) mem[aw_q[9:2]][8*b +: 8] <= wd_q[8*b +: 8];
                axi_if.bvalid <= 1'b1; axi_if.bresp <= RESP_OKAY; axi_if.bid <= next_bid;
            end
            if (axi_if.bvalid && axi_if.bready) begin
                axi_if.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0;
            end
            if (axi_if.arvalid && !ar_got) begin
                if (axi_if.arready) begin
                    ar_got <= 1'b1; axi_if.arready <= 1'b0; ar_q <= axi_if.araddr;
                end else axi_if.arready <= 1'b1;
            end
            if (ar_got && !axi_if.rvalid && !r_hold) begin
                axi_if.rvalid <= 1'b1; axi_if.rdata <= mem[ar_q[9:2]];
                axi_if.rresp <= rd_resp; axi_if.rid <= '0; axi_if.rlast <= 1'b1;
            end
            if (axi_if.rvalid && axi_if.rready) begin
                axi_if.rvalid <= 1'b0; ar_got <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [31:0] exp_aw [$];
    logic [35:0] exp_w  [$];
    logic [31:0] exp_ar [$];
    logic [31:0] exp_rsp [$];

    bit          aw_pend = 0, w_pend = 0;
    logic [31:0] aw_hold_addr, w_hold_data;

    always @(negedge aclk) begin
        logic [31:0] e;
        logic [35:0] ew;
        if (!areset_n) begin
            aw_pend = 0; w_pend = 0;
        end else begin
            if (aw_pend) chk("aw_stable", {axi_if.awvalid, axi_if.awaddr}, {1'b1, aw_hold_addr});
            if (w_pend)  chk("w_stable",  {axi_if.wvalid, axi_if.wdata},   {1'b1, w_hold_data});
            if (axi_if.awvalid && axi_if.awready) begin
                if (exp_aw.size() == 0) unexpected("aw");
                else begin
                    e = exp_aw.pop_front();
                    chk("awaddr", axi_if.awaddr, e);
                    chk("aw_ctl", {axi_if.awid, axi_if.awlen, axi_if.awsize, axi_if.awburst},
                        {8'h00, 8'h00, 3'd2, 2'b01});
                end
            end
            if (axi_if.wvalid && axi_if.wready) begin
                if (exp_w.size() == 0) unexpected("w");
                else begin
                    ew = exp_w.pop_front();
                    chk("wdata_wstrb", {axi_if.wdata, axi_if.wstrb}, ew);
                    chk("wlast", axi_if.wlast, 1'b1);
                end
            end
            if (axi_if.arvalid && axi_if.arready) begin
                if (exp_ar.size() == 0) unexpected("ar");
                else begin
                    e = exp_ar.pop_front();
                    chk("araddr", axi_if.araddr, e);
                    chk("ar_ctl", {axi_if.arid, axi_if.arlen, axi_if.arsize, axi_if.arburst},
                        {8'h00, 8'h00, 3'd2, 2'b01});
                end
            end
            if (tcdm_r_valid) begin
                if (exp_rsp.size() == 0) unexpected("r_valid");
                else begin
                    e = exp_rsp.pop_front();
                    chk("r_data", tcdm_r_data, e);
                end
            end
            aw_pend = axi_if.awvalid && !axi_if.awready;
            aw_hold_addr = axi_if.awaddr;
            w_pend = axi_if.wvalid && !axi_if.wready;
            w_hold_data = axi_if.wdata;
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] model_rdata = '0;

    task automatic send(input bit wen, input logic [31:0] add, input logic [3:0] be,
                        input logic [31:0] data, input logic [31:0] exp_addr,
                        input logic [31:0] exp_rd);
        int n;
        @(negedge aclk);
        tcdm_req = 1'b1; tcdm_wen = wen; tcdm_add = add; tcdm_be = be; tcdm_data = data;
        if (wen) begin
            exp_ar.push_back(exp_addr);
            model_rdata = exp_rd;
        end else begin
            exp_aw.push_back(exp_addr);
            exp_w.push_back({data, be});
        end
        exp_rsp.push_back(model_rdata);
        #1;
        n = 0;
        while (!tcdm_gnt && n < 20) begin
            @(negedge aclk); #1; n++;
        end
        if (!tcdm_gnt) begin
            total++; bad++;
            $display("FAIL gnt_timeout: gnt=%0b want 1 within 20 cycles", tcdm_gnt);
            tcdm_req = 1'b0;
            return;
        end
        @(posedge aclk); #1;
        tcdm_req = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge aclk); n++;
        end while (!tcdm_r_valid && n < 100);
        if (!tcdm_r_valid) begin
            total++; bad++;
            $display("FAIL %s_timeout: r_valid=0 want 1 within 100 cycles", nm);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge aclk);
        chk("rst_awvalid", axi_if.awvalid, 1'b0);
        chk("rst_wvalid", axi_if.wvalid, 1'b0);
        chk("rst_arvalid", axi_if.arvalid, 1'b0);
        chk("rst_bready", axi_if.bready, 1'b0);
        chk("rst_rready", axi_if.rready, 1'b0);
        chk("rst_r_valid", tcdm_r_valid, 1'b0);
        chk("rst_r_data", tcdm_r_data, 32'h0);
        chk("rst_err_sticky", err_sticky, 1'b0);
        chk("rst_err_count", err_count, 16'h0);
        areset_n = 1'b1;
        repeat (2) @(negedge aclk);

        // full-word write then read back
        send(1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h100, 32'h0);
        wait_done("wr_full");
        chk("wr_full_err", {err_sticky, err_count}, 17'h0);
        send(1'b1, 32'h100, 4'h0, 32'h0, 32'h100, 32'hDEADBEEF);
        wait_done("rd_full");

        // unaligned byte write: address aligned down, only byte 3 changes
        send(1'b0, 32'h103, 4'b1000, 32'h11223344, 32'h100, 32'h0);
        wait_done("wr_byte");
        send(1'b1, 32'h102, 4'h0, 32'h0, 32'h100, 32'h11ADBEEF);
        wait_done("rd_byte");

        // AWREADY withheld for 5 cycles; W only after AW
        aw_delay = 5;
        send(1'b0, 32'h104, 4'hF, 32'hA5A55A5A, 32'h104, 32'h0);
        wait_done("wr_slow_aw");
        aw_delay = 0;
        send(1'b1, 32'h104, 4'h0, 32'h0, 32'h104, 32'hA5A55A5A);
        wait_done("rd_slow_aw");

        // SLVERR on a read: data still delivered, error recorded
        rd_resp = RESP_SLVERR;
        send(1'b1, 32'h100, 4'h0, 32'h0, 32'h100, 32'h11ADBEEF);
        wait_done("rd_slverr");
        rd_resp = RESP_OKAY;
        chk("slverr_sticky", err_sticky, 1'b1);
        chk("slverr_count", err_count, 16'd1);

        // bid mismatch on a write
        next_bid = 8'h05;
        send(1'b0, 32'h108, 4'b0011, 32'h0000BEEF, 32'h108, 32'h0);
        wait_done("wr_badid");
        next_bid = 8'h00;
        chk("badid_count", err_count, 16'd2);

        // reset while waiting for read data
        r_hold = 1'b1;
        send(1'b1, 32'h100, 4'h0, 32'h0, 32'h100, 32'h11ADBEEF);
        n = 0;
        while (!axi_if.rready && n < 20) begin
            @(negedge aclk); n++;
        end
        chk("reach_rd_data", axi_if.rready, 1'b1);
        areset_n = 1'b0;
        #1;
        chk("mid_rst_valids", {axi_if.arvalid, axi_if.awvalid, axi_if.wvalid, axi_if.rready, axi_if.bready}, 5'b0);
        chk("mid_rst_r_valid", tcdm_r_valid, 1'b0);
        exp_rsp.delete();
        model_rdata = '0;
        repeat (2) @(negedge aclk);
        chk("mid_rst_err", {err_sticky, err_count}, 17'h0);
        r_hold = 1'b0;
        areset_n = 1'b1;
        repeat (2) @(negedge aclk);

        send(1'b0, 32'h200, 4'hF, 32'hCAFEF00D, 32'h200, 32'h0);
        wait_done("wr_after_rst");
        send(1'b1, 32'h200, 4'h0, 32'h0, 32'h200, 32'hCAFEF00D);
        wait_done("rd_after_rst");
        chk("post_rst_err", {err_sticky, err_count}, 17'h0);

        repeat (3) @(negedge aclk);
        chk("left_aw", exp_aw.size(), 0);
        chk("left_w", exp_w.size(), 0);
        chk("left_ar", exp_ar.size(), 0);
        chk("left_rsp", exp_rsp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
